// File: rtl/sap_control_sequencer_pkg.sv
// Shared SAP sequencer definitions: opcodes, control-word bit positions and T-state codes.
package sap_control_sequencer_pkg;

    localparam int unsigned CTRL_W = 12;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB = 4'h2;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam int unsigned CTRL_CP = 11;
    localparam int unsigned CTRL_EP = 10;
    localparam int unsigned CTRL_LM = 9;
    localparam int unsigned CTRL_CE = 8;
    localparam int unsigned CTRL_LI = 7;
    localparam int unsigned CTRL_EI = 6;
    localparam int unsigned CTRL_LA = 5;
    localparam int unsigned CTRL_EA = 4;
    localparam int unsigned CTRL_SU = 3;
    localparam int unsigned CTRL_EU = 2;
    localparam int unsigned CTRL_LB = 1;
    localparam int unsigned CTRL_LO = 0;

    // Encoding doubles as the externally visible T-state code.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_T6   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// T-state register: walks T1..T6 on advance, leaves IDLE on start, parks in HALT on HLT.
module sap_ring_counter
    import sap_control_sequencer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   advance,
    input  logic   start,
    input  logic   halt_req,
    output state_t state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state <= ST_T1;
                ST_T1:   if (advance) state <= ST_T2;
                ST_T2:   if (advance) state <= ST_T3;
                ST_T3:   if (advance) state <= ST_T4;
                ST_T4:   if (advance) state <= halt_req ? ST_HALT : ST_T5;
                ST_T5:   if (advance) state <= ST_T6;
                ST_T6:   if (advance) state <= ST_T1;
                default: state <= ST_HALT;
            endcase
        end
    end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP control sequencer: microcode decode of T-state and opcode into the control word,
// with free-run / single-step gating and a retired-instruction counter.
module sap_control_sequencer
    import sap_control_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_step_mode,
    input  logic              i_step,
    input  logic [OP_W-1:0]   i_opcode,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [2:0]        o_tstate,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_instr_count
);

    state_t            state;
    logic              advance;
    logic [CTRL_W-1:0] ucode;

    assign advance = !i_step_mode || i_step;

    sap_ring_counter u_ring (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .start    (i_start),
        .halt_req (i_opcode == OP_HLT),
        .state    (state)
    );

    // Microcode ROM; IDLE, HALT and unknown opcodes fall through to zero.
    always_comb begin
        ucode = '0;
        case (state)
            ST_T1: ucode = cbit(CTRL_EP) | cbit(CTRL_LM);
            ST_T2: ucode = cbit(CTRL_CP);
            ST_T3: ucode = cbit(CTRL_CE) | cbit(CTRL_LI);
            ST_T4: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB: ucode = cbit(CTRL_EI) | cbit(CTRL_LM);
                    OP_OUT:                 ucode = cbit(CTRL_EA) | cbit(CTRL_LO);
                    default:                ucode = '0;
                endcase
            end
            ST_T5: begin
                case (i_opcode)
                    OP_LDA:         ucode = cbit(CTRL_CE) | cbit(CTRL_LA);
                    OP_ADD, OP_SUB: ucode = cbit(CTRL_CE) | cbit(CTRL_LB);
                    default:        ucode = '0;
                endcase
            end
            ST_T6: begin
                case (i_opcode)
                    OP_ADD:  ucode = cbit(CTRL_EU) | cbit(CTRL_LA);
                    OP_SUB:  ucode = cbit(CTRL_EU) | cbit(CTRL_LA) | cbit(CTRL_SU);
                    default: ucode = '0;
                endcase
            end
            default: ucode = '0;
        endcase
    end

    // Gating by advance makes every load/increment fire once per T-state in step mode.
    assign o_ctrl   = advance ? ucode : '0;
    assign o_tstate = state;
    assign o_halted = (state == ST_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_instr_count <= '0;
        end else if (state == ST_T6 && advance) begin
            o_instr_count <= o_instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench: table-driven behavioural model checked every cycle on two counter widths.
module tb_sap_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  opcode = 4'h0;

    logic [11:0] ctrl8, ctrl2;
    logic [2:0]  tstate8, tstate2;
    logic        halted8, halted2;
    logic [7:0]  count8;
    logic [1:0]  count2;

    int checks = 0;
    int failures = 0;
    int m_phase = 0;
    int m_count = 0;

    logic [11:0] lda_exp [6] = '{12'h600, 12'h800, 12'h180, 12'h240, 12'h120, 12'h000};

    always #5 clk = ~clk;

    sap_control_sequencer #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
        .i_opcode(opcode), .o_ctrl(ctrl8), .o_tstate(tstate8), .o_halted(halted8),
        .o_instr_count(count8)
    );

    sap_control_sequencer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(start), .i_step_mode(step_mode), .i_step(step),
        .i_opcode(opcode), .o_ctrl(ctrl2), .o_tstate(tstate2), .o_halted(halted2),
        .o_instr_count(count2)
    );

    // Expected control word from the instruction tables, as whole words per phase.
    function automatic logic [11:0] exp_ctrl(input int ph, input logic [3:0] op, input bit adv);
        if (!adv || ph < 1 || ph > 6) return 12'h000;
        if (ph == 1) return 12'h600;
        if (ph == 2) return 12'h800;
        if (ph == 3) return 12'h180;
        case (op)
            4'h0: return (ph == 4) ? 12'h240 : (ph == 5) ? 12'h120 : 12'h000;
            4'h1: return (ph == 4) ? 12'h240 : (ph == 5) ? 12'h102 : 12'h024;
            4'h2: return (ph == 4) ? 12'h240 : (ph == 5) ? 12'h102 : 12'h02C;
            4'hE: return (ph == 4) ? 12'h011 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..6 T-states, 7 halted; count of completed instructions.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_count = 0;
        end else begin
            if (m_phase == 0) begin
                if (start) m_phase = 1;
            end else if (m_phase != 7 && (!step_mode || step)) begin
                if (m_phase == 4 && opcode == 4'hF) m_phase = 7;
                else if (m_phase == 6) begin
                    m_phase = 1;
                    m_count = m_count + 1;
                end else m_phase = m_phase + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] e;
        e = exp_ctrl(m_phase, opcode, !step_mode || step);
        check("ctrl8",   32'(ctrl8),   32'(e));
        check("ctrl2",   32'(ctrl2),   32'(e));
        check("tstate8", 32'(tstate8), 32'(m_phase));
        check("tstate2", 32'(tstate2), 32'(m_phase));
        check("halted8", 32'(halted8), 32'(m_phase == 7));
        check("halted2", 32'(halted2), 32'(m_phase == 7));
        check("count8",  32'(count8),  32'(m_count % 256));
        check("count2",  32'(count2),  32'(m_count % 4));
    end

    task automatic tick(input bit s, input bit md, input bit sp, input logic [3:0] op);
        @(posedge clk);
        #2;
        start = s; step_mode = md; step = sp; opcode = op;
        @(negedge clk);
        #1;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #2;
        rst = 1'b0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cp_pulses;
        int stray;
        bit sp;

        // Reset and idle
        tick(0, 0, 0, 4'h0);
        tick(0, 0, 0, 4'h0);
        check("rst_ctrl",   32'(ctrl8),   32'h0);
        check("rst_tstate", 32'(tstate8), 32'h0);
        check("rst_halted", 32'(halted8), 32'h0);
        check("rst_count",  32'(count8),  32'h0);
        release_rst();
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 4'h0);
        check("idle_tstate", 32'(tstate8), 32'h0);
        check("idle_ctrl",   32'(ctrl8),   32'h0);

        // LDA
        tick(1, 0, 0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 4'h0);
            check("lda_ctrl", 32'(ctrl8), 32'(lda_exp[i]));
        end
        tick(0, 0, 0, 4'h2);
        check("lda_ret_tstate", 32'(tstate8), 32'd1);
        check("lda_ret_count",  32'(count8),  32'd1);

        // SUB
        for (int t = 2; t <= 6; t++) begin
            tick(0, 0, 0, 4'h2);
            if (t == 5) check("sub_t5", 32'(ctrl8), 32'h102);
            if (t == 6) check("sub_t6", 32'(ctrl8), 32'h02C);
        end

        // OUT
        for (int t = 1; t <= 6; t++) begin
            tick(0, 0, 0, 4'hE);
            if (t == 4) check("out_t4", 32'(ctrl8), 32'h011);
        end

        // Single-step ADD, strobe every third cycle
        cp_pulses = 0;
        stray = 0;
        for (int i = 0; i < 18; i++) begin
            sp = (i % 3 == 2);
            tick(0, 1, sp, 4'h1);
            if (ctrl8[11]) cp_pulses++;
            if (!sp && ctrl8 != 12'h000) stray++;
            check("step_tstate", 32'(tstate8), 32'(1 + i / 3));
        end
        check("step_cp_once", 32'(cp_pulses), 32'd1);
        check("step_stray",   32'(stray),     32'd0);

        // HLT
        for (int t = 1; t <= 4; t++) tick(0, 0, 0, 4'hF);
        check("hlt_t4_tstate", 32'(tstate8), 32'd4);
        check("hlt_t4_ctrl",   32'(ctrl8),   32'h0);
        check("hlt_count",     32'(count8),  32'd4);
        tick(0, 0, 0, 4'hF);
        check("halt_tstate", 32'(tstate8), 32'd7);
        check("halt_flag",   32'(halted8), 32'd1);
        tick(1, 1, 1, 4'h0);
        tick(1, 0, 0, 4'h1);
        tick(0, 1, 1, 4'h2);
        check("halt_stuck", 32'(tstate8), 32'd7);
        check("halt_count", 32'(count8),  32'd4);

        // Reset mid-instruction
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        release_rst();
        tick(1, 0, 0, 4'h0);
        for (int t = 1; t <= 5; t++) tick(0, 0, 0, 4'h0);
        check("mid_t5", 32'(tstate8), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ctrl",   32'(ctrl8),   32'h0);
        check("mid_rst_tstate", 32'(tstate8), 32'h0);
        release_rst();
        tick(1, 0, 0, 4'h0);
        tick(0, 0, 0, 4'h5);
        check("restart_t1", 32'(tstate8), 32'd1);

        // Five NOPs: narrow counter wraps to 1
        for (int i = 0; i < 30; i++) tick(0, 0, 0, 4'h5);
        check("wrap_count2", 32'(count2), 32'd1);
        check("wrap_count8", 32'(count8), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
